// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: run-state encoding, saved-PC
// select constants and the jump/save decode helpers used by the top level.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_DONE
  } seq_state_t;

  localparam logic [1:0]  PCSEL_NONE = 2'b00;
  localparam logic [15:0] CYCLE_MAX  = 16'hFFFF;

  // When je and jne are both asserted the instruction behaves as je.
  function automatic logic jump_taken(input logic       je,
                                      input logic       jne,
                                      input logic       eq,
                                      input logic [1:0] sel);
    logic cond;
    cond = je ? eq : (jne ? !eq : 1'b0);
    return (sel != PCSEL_NONE) && cond;
  endfunction

  function automatic logic is_spc(input logic       je,
                                  input logic       jne,
                                  input logic       halt,
                                  input logic [1:0] sel);
    return (sel != PCSEL_NONE) && !je && !jne && !halt;
  endfunction

endpackage

// File: rtl/fetch_sequencer_pc_save_bank.sv
// Three saved-PC registers with one write port and one combinational read
// port; select 00 addresses no register and reads as zero.
module pc_save_bank
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [1:0]      wsel,
  input  logic [PC_W-1:0] wdata,
  input  logic [1:0]      rsel,
  output logic [PC_W-1:0] rdata
);

  logic [PC_W-1:0] pcreg1;
  logic [PC_W-1:0] pcreg2;
  logic [PC_W-1:0] pcreg3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcreg1 <= '0;
      pcreg2 <= '0;
      pcreg3 <= '0;
    end else if (we) begin
      case (wsel)
        2'b01:   pcreg1 <= wdata;
        2'b10:   pcreg2 <= wdata;
        2'b11:   pcreg3 <= wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (rsel)
      2'b01:   rdata = pcreg1;
      2'b10:   rdata = pcreg2;
      2'b11:   rdata = pcreg3;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Run controller and program counter for the 9-bit core: sequences start,
// step and halt, resolves je/jne/spc against the saved-PC bank, counts cycles.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0,
  parameter int SPC_OFFSET = 2
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            HaltInst,
  input  logic            JumpEqual,
  input  logic            JumpNotEqual,
  input  logic            OffsetEn,
  input  logic [1:0]      PCRegSelect,
  input  logic            EqFlag,
  output logic [PC_W-1:0] ProgCtr,
  output logic            Busy,
  output logic            Done,
  output logic [15:0]     CycleCount
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0] SPC_INC  = PC_W'(SPC_OFFSET);
  localparam logic [PC_W-1:0] PC_ONE   = PC_W'(1);

  seq_state_t      state;
  seq_state_t      next_state;
  logic [PC_W-1:0] pc_next;
  logic [15:0]     cc_next;
  logic            save_we;
  logic [PC_W-1:0] save_data;
  logic [PC_W-1:0] jump_target;

  pc_save_bank #(
    .PC_W (PC_W)
  ) u_bank (
    .clk   (Clk),
    .rst   (Reset),
    .we    (save_we),
    .wsel  (PCRegSelect),
    .wdata (save_data),
    .rsel  (PCRegSelect),
    .rdata (jump_target)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= SEQ_IDLE;
      ProgCtr    <= START_PC;
      CycleCount <= '0;
    end else begin
      state      <= next_state;
      ProgCtr    <= pc_next;
      CycleCount <= cc_next;
    end
  end

  // Decoder inputs only matter in RUN; halt beats both jumps and saves.
  always_comb begin
    next_state = state;
    pc_next    = ProgCtr;
    cc_next    = CycleCount;
    save_we    = 1'b0;
    save_data  = ProgCtr + PC_ONE + (OffsetEn ? SPC_INC : '0);
    case (state)
      SEQ_IDLE: begin
        pc_next = START_PC;
        if (Start) begin
          next_state = SEQ_RUN;
          cc_next    = '0;
        end
      end
      SEQ_RUN: begin
        cc_next = (CycleCount == CYCLE_MAX) ? CYCLE_MAX : CycleCount + 16'd1;
        if (HaltInst) begin
          next_state = SEQ_DONE;
        end else if (jump_taken(JumpEqual, JumpNotEqual, EqFlag, PCRegSelect)) begin
          pc_next = jump_target;
        end else begin
          pc_next = ProgCtr + PC_ONE;
        end
        save_we = is_spc(JumpEqual, JumpNotEqual, HaltInst, PCRegSelect);
      end
      SEQ_DONE: begin
        if (Start) begin
          next_state = SEQ_RUN;
          pc_next    = START_PC;
          cc_next    = '0;
        end
      end
      default: begin
        next_state = SEQ_IDLE;
        pc_next    = START_PC;
      end
    endcase
  end

  assign Busy = (state == SEQ_RUN);
  assign Done = (state == SEQ_DONE);

endmodule
